// File: rtl/mem_pkg.sv
// Shared types and constants for the parametrised single-port memory.
package mem_pkg;

    typedef enum logic {
        INIT,
        READY
    } mem_state_t;

    localparam logic        MEM_WR = 1'b0;
    localparam logic        MEM_RD = 1'b1;
    localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/mem_array.sv
// Storage array with per-byte write enables and a combinational read port.
module mem_array
    import mem_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 8,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned BE_W   = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [BE_W-1:0]   i_be,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_word
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (i_be[i]) begin
                    r_mem[i_wr_addr][i*BYTE_W +: BYTE_W] <= i_wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign o_rd_word = r_mem[i_rd_addr];

endmodule

// File: rtl/param_mem.sv
// Parametrised single-port memory: init sweep after reset/clear, byte-enable
// writes, registered read with valid strobe and out-of-range detection.
module param_mem
    import mem_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       DEPTH    = 8,
    parameter int unsigned       ADDR_W   = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     rd_wr,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/BYTE_W-1:0] wr_be,
    input  logic                     clear,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     addr_err
);

    localparam int unsigned       BE_W = DATA_W / BYTE_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    mem_state_t        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_busy;
    logic              r_addr_err;

    logic              w_accept;
    logic              w_addr_bad;
    logic              w_we;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_rd_word;

    assign w_addr_bad = ({1'b0, addr} >= (ADDR_W + 1)'(DEPTH));
    assign w_accept   = enable && !r_busy && !clear;

    // The sweep owns the write port while in INIT; user writes only reach it
    // once accepted, so the two sources never collide.
    always_comb begin
        w_we      = 1'b0;
        w_wr_addr = addr;
        w_be      = wr_be;
        w_wr_data = wr_data;
        if (r_state == INIT) begin
            w_we      = !clear;
            w_wr_addr = r_cnt;
            w_be      = '1;
            w_wr_data = INIT_VAL;
        end else if (w_accept && !w_addr_bad && rd_wr == MEM_WR) begin
            w_we = 1'b1;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_addr (w_wr_addr),
        .i_be      (w_be),
        .i_wr_data (w_wr_data),
        .i_rd_addr (addr),
        .o_rd_word (w_rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= INIT;
            r_cnt      <= '0;
            r_rd_data  <= '1;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b1;
            r_addr_err <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_addr_err <= 1'b0;
            case (r_state)
                INIT: begin
                    if (clear) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                READY: begin
                    if (clear) begin
                        r_cnt   <= '0;
                        r_state <= INIT;
                        r_busy  <= 1'b1;
                    end else if (w_accept) begin
                        if (w_addr_bad) begin
                            r_addr_err <= 1'b1;
                        end else if (rd_wr == MEM_RD) begin
                            r_rd_data  <= w_rd_word;
                            r_rd_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= INIT;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_param_mem.sv
// Scoreboard bench for param_mem: randomized and directed accesses checked
// against an array-based reference model with a busy countdown.
module tb_param_mem;

    localparam int unsigned       DATA_W   = 16;
    localparam int unsigned       DEPTH    = 6;
    localparam int unsigned       ADDR_W   = $clog2(DEPTH);
    localparam int unsigned       BE_W     = DATA_W / 8;
    localparam logic [DATA_W-1:0] INIT_VAL = 16'hC3A5;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              rd_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              clear;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              addr_err;

    param_mem #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .rd_wr    (rd_wr),
        .addr     (addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .clear    (clear),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                is_err;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              q[$];
    logic [DATA_W-1:0] m[DEPTH];
    logic [DATA_W-1:0] exp_rd_data;
    int                busy_left;
    int                compared = 0;
    int                mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void sweep_model();
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m[i] = INIT_VAL;
    endfunction

    function automatic void model_reset();
        exp_rd_data = '1;
        q.delete();
        sweep_model();
    endfunction

    // Reference behaviour for one rising edge, using the inputs held across it.
    function automatic void model_edge();
        if (rst) return;
        if (clear) begin
            sweep_model();
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (enable) begin
            if (int'(addr) >= DEPTH) begin
                q.push_back('{is_err: 1'b1, data: '0});
            end else if (rd_wr) begin
                exp_rd_data = m[addr];
                q.push_back('{is_err: 1'b0, data: m[addr]});
            end else begin
                for (int b = 0; b < BE_W; b++)
                    if (wr_be[b]) m[addr][8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.is_err) begin
                chk("addr_err_strobe", 32'(addr_err), 32'd1);
                chk("err_no_valid", 32'(rd_valid), 32'd0);
            end else begin
                chk("rd_valid_strobe", 32'(rd_valid), 32'd1);
                chk("read_data", 32'(rd_data), 32'(e.data));
                chk("read_no_err", 32'(addr_err), 32'd0);
            end
        end else begin
            chk("no_rd_valid", 32'(rd_valid), 32'd0);
            chk("no_addr_err", 32'(addr_err), 32'd0);
        end
        chk("busy", 32'(busy), 32'(busy_left > 0));
        chk("rd_data_hold", 32'(rd_data), 32'(exp_rd_data));
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic en, input logic rw, input int a,
                         input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be,
                         input logic clr);
        enable  = en;
        rd_wr   = rw;
        addr    = ADDR_W'(a);
        wr_data = d;
        wr_be   = be;
        clear   = clr;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, '0, '0, 1'b0);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b1, a, '0, '0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0; rd_wr = 1'b0; addr = '0; wr_data = '0; wr_be = '0; clear = 1'b0;
        model_reset();
        #1;
        chk("reset_rd_data", 32'(rd_data), 32'(16'hFFFF));
        chk("reset_busy", 32'(busy), 32'd1);
        step();
        step();
        rst = 1'b0;

        // Accesses during the post-reset sweep must be ignored.
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, 1'($urandom), $urandom_range(0, 7), DATA_W'($urandom), '1, 1'b0);
        read_all();

        drive(1'b1, 1'b0, 3, 16'h1234, 2'b11, 1'b0);
        drive(1'b1, 1'b0, 3, 16'hFFEE, 2'b01, 1'b0);
        drive(1'b1, 1'b1, 3, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 2, 16'hBEEF, 2'b00, 1'b0);
        drive(1'b1, 1'b1, 2, '0, '0, 1'b0);

        drive(1'b1, 1'b1, 7, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 6, 16'h0F0F, 2'b11, 1'b0);
        drive(1'b1, 1'b1, DEPTH - 1, '0, '0, 1'b0);
        read_all();

        for (int i = 0; i < 300; i++)
            drive(1'($urandom), 1'($urandom), $urandom_range(0, 7), DATA_W'($urandom),
                  BE_W'($urandom), ($urandom_range(0, 39) == 0));
        idle(DEPTH);

        for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b0, a, 16'h5A5A, 2'b11, 1'b0);
        drive(1'b1, 1'b0, 0, 16'h1111, 2'b11, 1'b1);
        idle(DEPTH);
        read_all();

        drive(1'b1, 1'b1, 2, '0, '0, 1'b0);
        drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
        idle(3);
        rst = 1'b1;
        model_reset();
        #1;
        chk("midsweep_rst_rd_data", 32'(rd_data), 32'(16'hFFFF));
        chk("midsweep_rst_busy", 32'(busy), 32'd1);
        step();
        rst = 1'b0;
        idle(DEPTH);
        read_all();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
